spi_frame_buffer: RTL
=====================

# spi_frame_buffer

Parametrised SPI-slave frame buffer for the compressive-sensing datapath. It receives a frame of DEPTH words of DATA_W bits from the host over SPI and stores them in an internal buffer. It can apply an optional per-frame transform, then returns the frame to the host over the same SPI link. It replaces the fixed 64×8 receive/send pair with explicit reset, exact frame-length accounting, selectable output ordering and status outputs.

## Interface
Parameters:
- DATA_W, 8: bits per SPI word; must be ≥ 2.
- DEPTH, 64: words per frame; must be ≥ 2.

Ports:
- clk  in  1  system clock. Must run at ≥ 8× the SCK frequency.
- rst  in  1  synchronous, active-high reset.
- SCK  in  1  SPI clock, asynchronous to clk. SPI mode 0.
- SSEL  in  1  SPI slave select, active low, asynchronous.
- MOSI  in  1  SPI data in, MSB first.
- MISO  out  1  SPI data out, MSB first.
- mode  in  2  per-frame transform:
  - 0 = pass-through.
  - 1 = reverse order.
  - 2 = running sum.
  - 3 = treated as 0.
- frame_received  out  1  one-cycle pulse when the DEPTH-th word has been stored.
- frame_sent  out  1  one-cycle pulse when the DEPTH-th word has been shifted out.
- busy_tx  out  1  high while in state SEND.
- word_count  out  $clog2(DEPTH+1)  words stored (RECV) or words sent (SEND).

## Operation
- Input synchronisation: SCK, SSEL and MOSI pass through 2-FF synchronisers. SCK rise and fall are detected from the synchronised samples.
- Receive shifting: on a detected SCK rise with SSEL low, the synchronised MOSI is shifted into rx_shift and bit_cnt increments.
- Word completion: when bit_cnt reaches DATA_W, rx_valid pulses for one cycle and bit_cnt clears.
- Partial words: an SSEL rise, or SSEL high, clears bit_cnt and discards the partial word.
- Frames may span any number of SSEL transactions. Only rst or frame completion ends a frame.
- State machine:
  - RECV (reset state):
    - On the first rx_valid of a frame, latch mode into mode_q.
    - Each rx_valid writes buf[wr_ptr] and increments wr_ptr and word_count.
    - Running sum (mode_q = 2): the value written is acc + rx_word mod 2^DATA_W, and acc is updated to that value. acc clears at frame start.
    - When word_count reaches DEPTH: pulse frame_received, clear the counters, go to SEND.
  - SEND:
    - The next tx word is buf[k] for mode_q = 0 or 2, or buf[DEPTH-1-k] for mode_q = 1, where k = words sent.
    - tx_shift is loaded with the next word on SSEL fall, and after each DATA_W-th SCK fall while SSEL stays low.
    - On a detected SCK fall with SSEL low, tx_shift shifts left. MISO = tx_shift MSB.
    - MOSI data is ignored; no writes occur.
    - A word counts as sent on its DATA_W-th SCK rise.
    - After DEPTH words are sent: pulse frame_sent, clear the counters, return to RECV.
- Outside SEND, MISO = 0.
- Exactly DEPTH words are stored and sent. There is no off-by-one at DEPTH-1.

## Timing
- Reset values: MISO=0, frame_received=0, frame_sent=0, busy_tx=0, word_count=0, state=RECV. Counters, acc, mode_q and tx_shift are all 0. Buffer contents are undefined.
- MOSI sample: taken 3 clk after the SCK rise at the pin (2 synchroniser stages + edge register).
- rx_valid: 1 clk after the DATA_W-th detected rise.
- Buffer write: in the cycle after rx_valid.
- frame_received: asserted in the cycle after the final write. busy_tx rises in that same cycle.
- MISO update: 3 clk after the SCK fall at the pin. With clk ≥ 8× SCK, MISO is stable before the next SCK rise.
- SCK edge and SSEL rise detected in the same cycle: the edge is processed first. A word completed by that edge counts.
- rst mid-frame: abandons the frame, clears all counters, returns to RECV. The next word starts a new frame.
- Running-sum arithmetic: wraps modulo 2^DATA_W, no saturation.
- word_count: stays at 0..DEPTH; never wraps.

## Structure
- Shared package spi_pkg:
  - state encoding (RECV, SEND);
  - mode encodings (MODE_PASS, MODE_REV, MODE_SUM);
  - a sync stage count constant = 2.
- Sub-module spi_slave_phy, parametrised by DATA_W. Contains the synchronisers, edge detection, rx_shift, bit_cnt, tx_shift and MISO. Outputs rx_valid, rx_word and tx_done. Input tx_load with tx_word.
- The top level holds the buffer (inferred RAM, DEPTH×DATA_W), pointers, acc, mode_q and the FSM.

## Test plan
- Pass-through: DATA_W=8, DEPTH=4, mode=0. Send 0x11,0x22,0x33,0x44 -> frame_received pulses once; the next 4 words on MISO are 0x11,0x22,0x33,0x44; frame_sent pulses once; state returns to RECV.
- Reverse order: mode=1, same frame -> MISO returns 0x44,0x33,0x22,0x11.
- Running sum with wrap: mode=2. Send 0x80,0x90,0x01,0x10 -> MISO returns 0x80,0x10,0x11,0x21.
- Partial word discard: raise SSEL after 5 bits, then send a full 0xA5 -> the stored word is 0xA5 and word_count increments by 1 only.
- Mid-frame reset: assert rst after 2 words, then send a 4-word frame -> frame_received fires after exactly 4 more words and the returned data is the post-reset frame.
- Width/depth variant: DATA_W=12, DEPTH=3. Send 0xABC,0x123,0xFFF -> echoed unchanged; MISO stays 0 outside SEND.

Source files
------------

// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int c_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    RECV = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_REV  = 2'd1,
    MODE_SUM  = 2'd2
  } mode_t;

  // Encoding 3 is reserved and behaves as pass-through.
  function automatic mode_t decodeMode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_REV;
      2'd2:    return MODE_SUM;
      default: return MODE_PASS;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_slave_phy.sv
// ============================================================================
// Module      : spi_slave_phy
// Description : SPI mode-0 slave bit engine: synchronisers, edge detect, shifters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_phy
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              txEn,
  input  logic              txLoad,
  input  logic [DATA_W-1:0] txWord,
  output logic              txReq,
  output logic              txDone,
  output logic              rxValid,
  output logic [DATA_W-1:0] rxWord
);

  localparam int c_CNT_W = $clog2(DATA_W + 1);

  logic [c_SYNC_STAGES-1:0] r_sckSync;
  logic [c_SYNC_STAGES-1:0] r_sselSync;
  logic [c_SYNC_STAGES-1:0] r_mosiSync;
  logic                     r_sckPrev;
  logic                     r_sselPrev;
  logic [DATA_W-1:0]        r_rxShift;
  logic [DATA_W-1:0]        r_txShift;
  logic [c_CNT_W-1:0]       r_bitCnt;
  logic [c_CNT_W-1:0]       r_fallCnt;
  logic                     r_rxValid;

  logic w_sck;
  logic w_ssel;
  logic w_mosi;
  logic w_sckRise;
  logic w_sckFall;
  logic w_sselFall;
  logic w_selActive;
  logic w_lastBit;
  logic w_lastFall;

  assign w_sck       = r_sckSync[c_SYNC_STAGES-1];
  assign w_ssel      = r_sselSync[c_SYNC_STAGES-1];
  assign w_mosi      = r_mosiSync[c_SYNC_STAGES-1];
  assign w_sckRise   = w_sck & ~r_sckPrev;
  assign w_sckFall   = ~w_sck & r_sckPrev;
  assign w_sselFall  = ~w_ssel & r_sselPrev;
  // Previous select sample lets an edge coinciding with the SSEL rise still count.
  assign w_selActive = ~r_sselPrev;
  assign w_lastBit   = (r_bitCnt == c_CNT_W'(DATA_W - 1));
  assign w_lastFall  = (r_fallCnt == c_CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sckSync  <= '0;
      r_sselSync <= '1;
      r_mosiSync <= '0;
      r_sckPrev  <= 1'b0;
      r_sselPrev <= 1'b1;
    end else begin
      r_sckSync  <= {r_sckSync[c_SYNC_STAGES-2:0], SCK};
      r_sselSync <= {r_sselSync[c_SYNC_STAGES-2:0], SSEL};
      r_mosiSync <= {r_mosiSync[c_SYNC_STAGES-2:0], MOSI};
      r_sckPrev  <= w_sck;
      r_sselPrev <= w_ssel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxShift <= '0;
      r_bitCnt  <= '0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      if (w_sckRise && w_selActive) begin
        r_rxShift <= {r_rxShift[DATA_W-2:0], w_mosi};
        if (w_lastBit) begin
          r_bitCnt  <= '0;
          r_rxValid <= 1'b1;
        end else begin
          r_bitCnt <= r_bitCnt + 1'b1;
        end
      end
      if (w_ssel) r_bitCnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txShift <= '0;
      r_fallCnt <= '0;
    end else begin
      if (txLoad) begin
        r_txShift <= txWord;
      end else if (w_sckFall && w_selActive && !w_lastFall) begin
        r_txShift <= {r_txShift[DATA_W-2:0], 1'b0};
      end
      if (w_sckFall && w_selActive) begin
        r_fallCnt <= w_lastFall ? '0 : r_fallCnt + 1'b1;
      end
      if (w_ssel) r_fallCnt <= '0;
    end
  end

  assign txReq   = w_sselFall | (w_sckFall & w_selActive & w_lastFall);
  assign txDone  = r_rxValid;
  assign rxValid = r_rxValid;
  assign rxWord  = r_rxShift;
  assign MISO    = txEn & r_txShift[DATA_W-1];

endmodule

`default_nettype wire

// File: rtl/spi_frame_buffer.sv
// ============================================================================
// Module      : spi_frame_buffer
// Description : SPI-slave frame buffer: stores DEPTH words, returns them transformed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_buffer
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SCK,
  input  logic                       SSEL,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [1:0]                 mode,
  output logic                       frame_received,
  output logic                       frame_sent,
  output logic                       busy_tx,
  output logic [$clog2(DEPTH+1)-1:0] word_count
);

  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam int c_ADDR_W = $clog2(DEPTH);

  state_t              r_state;
  state_t              w_nextState;
  mode_t               r_modeQ;
  mode_t               w_modeEff;
  logic [c_CNT_W-1:0]  r_wordCount;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_wrData;
  logic                r_wrEn;
  logic                r_frameReceived;
  logic                r_frameSent;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_busy;
  logic                w_rxValid;
  logic [DATA_W-1:0]   w_rxWord;
  logic                w_txDone;
  logic                w_txReq;
  logic                w_first;
  logic [DATA_W-1:0]   w_sum;
  logic [c_ADDR_W-1:0] w_k;
  logic [c_ADDR_W-1:0] w_rdIdx;
  logic                w_frameDone;
  logic                w_sendDone;
  logic                w_lastWord;

  assign w_busy     = (r_state == SEND);
  assign w_first    = (r_wordCount == '0);
  assign w_modeEff  = w_first ? decodeMode(mode) : r_modeQ;
  assign w_sum      = (w_first ? '0 : r_acc) + w_rxWord;
  assign w_lastWord = (r_wordCount == c_CNT_W'(DEPTH - 1));
  assign w_k        = r_wordCount[c_ADDR_W-1:0];
  assign w_rdIdx    = (r_modeQ == MODE_REV) ? c_ADDR_W'(DEPTH - 1) - w_k : w_k;

  spi_slave_phy #(
    .DATA_W (DATA_W)
  ) u_phy (
    .clk     (clk),
    .rst     (rst),
    .SCK     (SCK),
    .SSEL    (SSEL),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .txEn    (w_busy),
    .txLoad  (w_busy & w_txReq),
    .txWord  (r_mem[w_rdIdx]),
    .txReq   (w_txReq),
    .txDone  (w_txDone),
    .rxValid (w_rxValid),
    .rxWord  (w_rxWord)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= RECV;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_frameDone = 1'b0;
    w_sendDone  = 1'b0;
    case (r_state)
      RECV: if (r_wrEn && w_lastWord) begin
        w_frameDone = 1'b1;
        w_nextState = SEND;
      end
      SEND: if (w_txDone && w_lastWord) begin
        w_sendDone  = 1'b1;
        w_nextState = RECV;
      end
      default: w_nextState = RECV;
    endcase
  end

  // Received word is transformed and staged here, then written one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrEn   <= 1'b0;
      r_wrData <= '0;
      r_acc    <= '0;
      r_modeQ  <= MODE_PASS;
    end else begin
      r_wrEn <= 1'b0;
      if (!w_busy && w_rxValid) begin
        r_wrEn   <= 1'b1;
        r_wrData <= (w_modeEff == MODE_SUM) ? w_sum : w_rxWord;
        r_acc    <= w_sum;
        if (w_first) r_modeQ <= decodeMode(mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_wrEn && !w_busy) r_mem[w_k] <= r_wrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wordCount     <= '0;
      r_frameReceived <= 1'b0;
      r_frameSent     <= 1'b0;
    end else begin
      r_frameReceived <= w_frameDone;
      r_frameSent     <= w_sendDone;
      if (w_frameDone || w_sendDone) begin
        r_wordCount <= '0;
      end else if ((!w_busy && r_wrEn) || (w_busy && w_txDone)) begin
        r_wordCount <= r_wordCount + 1'b1;
      end
    end
  end

  assign frame_received = r_frameReceived;
  assign frame_sent     = r_frameSent;
  assign busy_tx        = w_busy;
  assign word_count     = r_wordCount;

endmodule

`default_nettype wire
